// File: rtl/uart_tx_param.sv
// uart_tx_param: buffered UART transmitter with a configurable frame and FIFO.
// Bytes are queued through buffer_write and shifted out LSB first on
// serial_out, one bit per 16 en_16_x_baud strobes.
// Ports:
//   clk                 system clock
//   btnCpuReset         asynchronous active-low reset; clears all state
//   en_16_x_baud        one-clk strobe at 16x the baud rate
//   buffer_reset        synchronous FIFO flush + overflow clear
//   data_in             word to enqueue (DATA_BITS wide)
//   buffer_write        enqueue data_in on this edge
//   serial_out          line output, idles high
//   buffer_full         count == FIFO_DEPTH
//   buffer_half_full    count >= FIFO_DEPTH/2
//   buffer_data_present count != 0
//   tx_busy             shifter not idle
//   overflow            sticky, set by a rejected write
module uart_tx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 btnCpuReset,
    input  logic                 en_16_x_baud,
    input  logic                 buffer_reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 buffer_write,
    output logic                 serial_out,
    output logic                 buffer_full,
    output logic                 buffer_half_full,
    output logic                 buffer_data_present,
    output logic                 tx_busy,
    output logic                 overflow
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = 4;

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  HALF_C    = CNT_W'(FIFO_DEPTH / 2);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(15);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 serial_out_q, serial_out_d;
    logic                 tx_busy_q, tx_busy_d;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 full_q, full_d;
    logic                 half_q, half_d;
    logic                 present_q, present_d;

    logic                 pop;
    logic                 push;
    logic                 bit_end;
    logic [DATA_BITS-1:0] head;

    assign head    = fifo_mem[rd_ptr_q];
    assign bit_end = en_16_x_baud && (tick_q == TICK_LAST);

    // State register
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and shifter datapath
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;

        if (en_16_x_baud && (state_q != S_IDLE)) begin
            tick_d = tick_q + TICK_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (en_16_x_baud && (count_q != '0)) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    parity_d = (PARITY == 2) ? ~(^head) : (^head);
                    tick_d   = '0;
                    bit_d    = '0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the line changes on the same edge as the FSM
    always_comb begin
        serial_out_d = 1'b1;
        tx_busy_d    = (state_d != S_IDLE);
        case (state_d)
            S_START:  serial_out_d = 1'b0;
            S_DATA:   serial_out_d = shift_d[0];
            S_PARITY: serial_out_d = parity_d;
            default:  serial_out_d = 1'b1;
        endcase
    end

    // Shifter registers
    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            serial_out_q <= 1'b1;
            tx_busy_q    <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            serial_out_q <= serial_out_d;
            tx_busy_q    <= tx_busy_d;
        end
    end

    // FIFO bookkeeping; a write to a full FIFO is only taken when a pop frees a slot
    always_comb begin
        push       = buffer_write && ((count_q != DEPTH_C) || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (buffer_reset) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (buffer_write && !push) begin
                overflow_d = 1'b1;
            end
        end

        full_d    = (count_d == DEPTH_C);
        half_d    = (count_d >= HALF_C);
        present_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
            half_q     <= 1'b0;
            present_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            full_q     <= full_d;
            half_q     <= half_d;
            present_q  <= present_d;
        end
    end

    // Storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (push && !buffer_reset) begin
            fifo_mem[wr_ptr_q] <= data_in;
        end
    end

    assign serial_out          = serial_out_q;
    assign tx_busy             = tx_busy_q;
    assign buffer_full         = full_q;
    assign buffer_half_full    = half_q;
    assign buffer_data_present = present_q;
    assign overflow            = overflow_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1/16, 7E2/16, 8O1/4) sharing
// clock, reset, strobe and buffer_reset. Frames are compared bit by bit
// against hand-computed line patterns (bit 0 = start bit).
module tb_uart_tx_param;

    logic       clk;
    logic       rst_n;
    logic       baud;
    logic       breset;
    logic [7:0] din0;
    logic [6:0] din1;
    logic [7:0] din2;
    logic [2:0] wr;
    logic [2:0] so;
    logic [2:0] full;
    logic [2:0] half;
    logic [2:0] present;
    logic [2:0] busy;
    logic [2:0] ovf;

    int total = 0;
    int bad   = 0;

    uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .btnCpuReset(rst_n), .en_16_x_baud(baud), .buffer_reset(breset),
        .data_in(din0), .buffer_write(wr[0]), .serial_out(so[0]),
        .buffer_full(full[0]), .buffer_half_full(half[0]),
        .buffer_data_present(present[0]), .tx_busy(busy[0]), .overflow(ovf[0])
    );

    uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .btnCpuReset(rst_n), .en_16_x_baud(baud), .buffer_reset(breset),
        .data_in(din1), .buffer_write(wr[1]), .serial_out(so[1]),
        .buffer_full(full[1]), .buffer_half_full(half[1]),
        .buffer_data_present(present[1]), .tx_busy(busy[1]), .overflow(ovf[1])
    );

    uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .btnCpuReset(rst_n), .en_16_x_baud(baud), .buffer_reset(breset),
        .data_in(din2), .buffer_write(wr[2]), .serial_out(so[2]),
        .buffer_full(full[2]), .buffer_half_full(half[2]),
        .buffer_data_present(present[2]), .tx_busy(busy[2]), .overflow(ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [12:0] frame;
        int          nbits;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       half;
        logic       full;
        logic       ovf;
    } fill_t;

    vec_t  vecs  [8];
    fill_t fills [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; drives one write edge and returns at the following negedge
    task automatic write_byte(input int inst, input logic [7:0] d);
        din0      = d;
        din1      = d[6:0];
        din2      = d;
        wr[inst]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr[inst]  = 1'b0;
    endtask

    // Samples a whole frame; when started is 0 the next posedge is the pop edge,
    // when 1 the pop edge has already passed and the first sample is taken now.
    task automatic expect_frame(input int inst, input logic [12:0] frame, input int nbits,
                                input bit started, input string tag);
        logic first_bad;
        logic act;
        logic busy_ok;
        for (int b = 0; b < nbits; b++) begin
            first_bad = 1'b0;
            act       = frame[b];
            busy_ok   = 1'b1;
            for (int s = 0; s < 16; s++) begin
                if (!(started && b == 0 && s == 0)) begin
                    @(posedge clk);
                    @(negedge clk);
                end
                if (!first_bad) begin
                    act = so[inst];
                    if (so[inst] !== frame[b]) first_bad = 1'b1;
                end
                if (busy[inst] !== 1'b1) busy_ok = 1'b0;
            end
            check($sformatf("%s line bit%0d", tag, b), 32'(act), 32'(frame[b]));
            check($sformatf("%s busy bit%0d", tag, b), 32'(busy_ok), 32'd1);
        end
        @(posedge clk);
        @(negedge clk);
        check($sformatf("%s busy end", tag), 32'(busy[inst]), 32'd0);
        check($sformatf("%s line end", tag), 32'(so[inst]), 32'd1);
    endtask

    initial begin
        // Single-frame vectors: {instance, data, line pattern LSB=start, bit count}
        vecs[0] = '{0, 8'h55, 13'(10'b1010101010), 10};
        vecs[1] = '{0, 8'hA3, 13'(10'b1101000110), 10};
        vecs[2] = '{1, 8'h03, 13'(11'b11000000110), 11};
        vecs[3] = '{1, 8'h55, 13'(11'b11010101010), 11};
        vecs[4] = '{1, 8'h40, 13'(11'b11110000000), 11};
        vecs[5] = '{2, 8'h01, 13'(11'b10000000010), 11};
        vecs[6] = '{2, 8'h00, 13'(11'b11000000000), 11};
        vecs[7] = '{2, 8'hFF, 13'(11'b11111111110), 11};

        // Depth-4 fill with the strobe off: flags after each write
        fills[0] = '{8'h11, 1'b0, 1'b0, 1'b0};
        fills[1] = '{8'h23, 1'b1, 1'b0, 1'b0};
        fills[2] = '{8'h33, 1'b1, 1'b0, 1'b0};
        fills[3] = '{8'h47, 1'b1, 1'b1, 1'b0};
        fills[4] = '{8'h55, 1'b1, 1'b1, 1'b1};

        rst_n  = 1'b0;
        baud   = 1'b0;
        breset = 1'b0;
        din0   = '0;
        din1   = '0;
        din2   = '0;
        wr     = '0;
        repeat (3) @(negedge clk);

        check("reset line", 32'(so), 32'h7);
        check("reset busy", 32'(busy), 32'h0);
        check("reset present", 32'(present), 32'h0);
        check("reset full", 32'(full), 32'h0);
        check("reset half", 32'(half), 32'h0);
        check("reset ovf", 32'(ovf), 32'h0);

        rst_n = 1'b1;
        @(negedge clk);
        baud = 1'b1;

        for (int i = 0; i < 8; i++) begin
            write_byte(vecs[i].inst, vecs[i].data);
            check($sformatf("vec%0d present", i), 32'(present[vecs[i].inst]), 32'd1);
            expect_frame(vecs[i].inst, vecs[i].frame, vecs[i].nbits, 1'b0,
                         $sformatf("vec%0d", i));
        end

        // Fill depth-4 FIFO, fifth write overflows
        baud = 1'b0;
        for (int k = 0; k < 5; k++) begin
            write_byte(2, fills[k].data);
            check($sformatf("fill%0d present", k), 32'(present[2]), 32'd1);
            check($sformatf("fill%0d half", k), 32'(half[2]), 32'(fills[k].half));
            check($sformatf("fill%0d full", k), 32'(full[2]), 32'(fills[k].full));
            check($sformatf("fill%0d ovf", k), 32'(ovf[2]), 32'(fills[k].ovf));
        end
        check("fill idle busy", 32'(busy[2]), 32'd0);
        baud = 1'b1;
        expect_frame(2, 13'(11'b11000100010), 11, 1'b0, "fifo0");
        expect_frame(2, 13'(11'b10001000110), 11, 1'b0, "fifo1");
        expect_frame(2, 13'(11'b11001100110), 11, 1'b0, "fifo2");
        expect_frame(2, 13'(11'b11010001110), 11, 1'b0, "fifo3");
        check("drain present", 32'(present[2]), 32'd0);
        repeat (20) @(negedge clk);
        check("dropped byte not sent busy", 32'(busy[2]), 32'd0);
        check("dropped byte not sent line", 32'(so[2]), 32'd1);
        check("ovf sticky", 32'(ovf[2]), 32'd1);

        // buffer_reset clears overflow, and beats a write on the same edge
        baud   = 1'b0;
        breset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        breset = 1'b0;
        check("breset ovf", 32'(ovf[2]), 32'd0);
        breset = 1'b1;
        write_byte(2, 8'h66);
        breset = 1'b0;
        check("breset vs write present", 32'(present[2]), 32'd0);

        // Full FIFO, write lands on the pop edge
        write_byte(2, 8'h81);
        write_byte(2, 8'h02);
        write_byte(2, 8'h0F);
        write_byte(2, 8'h70);
        check("prefull full", 32'(full[2]), 32'd1);
        baud = 1'b1;
        din2 = 8'hFE;
        wr[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr[2] = 1'b0;
        check("pop+write full", 32'(full[2]), 32'd1);
        check("pop+write ovf", 32'(ovf[2]), 32'd0);
        expect_frame(2, 13'(11'b11100000010), 11, 1'b1, "pw0");
        expect_frame(2, 13'(11'b10000000100), 11, 1'b0, "pw1");
        expect_frame(2, 13'(11'b11000011110), 11, 1'b0, "pw2");
        expect_frame(2, 13'(11'b10011100000), 11, 1'b0, "pw3");
        expect_frame(2, 13'(11'b10111111100), 11, 1'b0, "pw4");
        check("pw drain present", 32'(present[2]), 32'd0);

        // Async reset in the middle of a data bit, with bytes still queued
        write_byte(0, 8'hA5);
        write_byte(0, 8'h11);
        write_byte(0, 8'h22);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("pre-reset line d1", 32'(so[0]), 32'd0);
        check("pre-reset present", 32'(present[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async line", 32'(so[0]), 32'd1);
        check("async busy", 32'(busy[0]), 32'd0);
        check("async present", 32'(present[0]), 32'd0);
        check("async half", 32'(half[0]), 32'd0);
        check("async full", 32'(full[0]), 32'd0);
        check("async ovf", 32'(ovf[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset idle line", 32'(so[0]), 32'd1);
        write_byte(0, 8'h3C);
        check("post-reset present", 32'(present[0]), 32'd1);
        expect_frame(0, 13'(10'b1001111000), 10, 1'b0, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised buffered UART transmitter, the next generation of the fixed 8N1 `uart_tx6` used by the logic-analyser kernel. It adds a configurable frame (data bits, parity, stop bits), a configurable FIFO depth, a sticky overflow flag and a busy indicator. It sits between the kernel's command/control logic and the `uart_txd` pin, and is paced by the shared `en_16_x_baud` strobe.

## Interface
- `DATA_BITS`, 8, data bits per frame, 5..9, sent LSB first.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1, stop bits per frame, 1 or 2.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, at least 2.
- `clk` in 1: system clock, 100 MHz.
- `btnCpuReset` in 1: asynchronous, active-low reset; clears all state.
- `en_16_x_baud` in 1: one-`clk` strobe at 16× the baud rate.
- `buffer_reset` in 1: synchronous FIFO flush and overflow clear; does not abort the frame in flight.
- `data_in` in DATA_BITS: byte to enqueue.
- `buffer_write` in 1: enqueue `data_in` on this edge.
- `serial_out` out 1: line output; idles high.
- `buffer_full` out 1: count == FIFO_DEPTH.
- `buffer_half_full` out 1: count >= FIFO_DEPTH/2.
- `buffer_data_present` out 1: count != 0.
- `tx_busy` out 1: the shifter is not IDLE.
- `overflow` out 1: sticky; set by a rejected write.

## Operation
- FIFO: circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap naturally, plus a count of log2(FIFO_DEPTH)+1 bits.
- Write with count < FIFO_DEPTH: data stored; count increments.
- Write while full: accepted only if a pop happens on the same edge (count unchanged). Otherwise the data is dropped, the FIFO is unchanged, and `overflow` is set.
- Simultaneous write and pop when not full: count unchanged; both pointers advance.
- Pop occurs only on the IDLE→START transition.
- Shifter FSM states and transitions:
  - IDLE: `serial_out`=1. When the FIFO is not empty and `en_16_x_baud`=1, pop the head into the shift register, compute parity, clear the tick counter and go to START.
  - START: `serial_out`=0 for 16 ticks, then go to DATA.
  - DATA: output shift[0] for 16 ticks per bit and shift right. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: output the XOR of the data bits for even parity, or its inverse for odd parity. Hold 16 ticks, then go to STOP.
  - STOP: `serial_out`=1 for 16×STOP_BITS ticks, then go to IDLE.
- Tick: a 4-bit counter advances only when `en_16_x_baud`=1. A bit ends on the strobe where the counter is 15.
- Back-to-back frames: if the FIFO is non-empty at STOP exit, the next START begins on the following strobe (one strobe of idle-high spacing).
- `buffer_reset` vs. write on the same edge: `buffer_reset` wins; the FIFO ends empty.
- `buffer_reset` during a frame: the frame in flight completes normally.
- `btnCpuReset` low at any time: FSM returns to IDLE, FIFO empties, `overflow` clears. `serial_out` goes high immediately (asynchronously), truncating any frame.

## Timing
- Reset values: `serial_out`=1, `buffer_full`=0, `buffer_half_full`=0, `buffer_data_present`=0, `tx_busy`=0, `overflow`=0.
- All outputs are registered or decoded from registers; no combinational path from inputs to outputs.
- Write at edge N: `buffer_data_present` is high after edge N.
- With `en_16_x_baud` held at 1 and the shifter in IDLE, `serial_out` falls after edge N+1, and `tx_busy` rises at the same edge.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × 16 strobes.
- `tx_busy` falls on the edge that leaves STOP.
- `en_16_x_baud` low freezes the FSM and tick counter; the FIFO still accepts writes.

## Test plan
- Default parameters, `en_16_x_baud`=1, write 0x55 → `serial_out` shows start 0, then bits 1,0,1,0,1,0,1,0, then stop 1, each held 16 clocks. `tx_busy` is high for 160 clocks.
- DATA_BITS=7, PARITY=1, STOP_BITS=2, write 0x03 → start, bits 1,1,0,0,0,0,0, parity 0, two stop bits. Total 176 clocks.
- PARITY=2, write 0x01 with DATA_BITS=8 → parity bit 0. Write 0x00 → parity bit 1.
- FIFO_DEPTH=4, `en_16_x_baud`=0, write 5 bytes → `buffer_half_full` after the 2nd write, `buffer_full` after the 4th. The 5th write is dropped and `overflow`=1. Enabling the strobe transmits exactly the first 4 bytes in order, back-to-back.
- Full FIFO with a write on the same edge as a pop → count stays 4, `overflow` stays 0, and the new byte is transmitted last.
- Assert `btnCpuReset` low mid-DATA bit → `serial_out`=1 and all flags 0 immediately. After release, a new write transmits a clean frame.
